pwm_deadtime_core: RTL and testbench

- MMIO slot core placed directly downstream of the PWM generator core.
- Takes one raw PWM bit per channel and drives a complementary high-side/low-side gate pair for each channel.
- Inserts a programmable dead time on every transition so the hi and lo outputs of a channel are never both asserted.
- Latches an external fault input and forces all gate outputs inactive until software clears it.

---
 rtl/pwm_deadtime_core.sv | 202 ++++++++++++++++++++
 tb/tb_pwm_deadtime_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_core.sv
// Complementary high/low gate drive with per-channel programmable dead time and a latched fault shutdown.
// Define PWM_DT_POL_EN to add the per-output polarity register at address 0x03.
module pwm_deadtime_core #(
    parameter int               CH     = 6,
    parameter int               DT_W   = 16,
    parameter logic [DT_W-1:0]  DT_RST = 16'd10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    reg_addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [CH-1:0] pwm_in,
    input  logic          fault_in,
    output logic [CH-1:0] pwm_hi,
    output logic [CH-1:0] pwm_lo
);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_LO_ON = 3'd1;
    localparam logic [2:0] ST_DT_H  = 3'd2;
    localparam logic [2:0] ST_HI_ON = 3'd3;
    localparam logic [2:0] ST_DT_L  = 3'd4;

    logic            en_r;
    logic            fault_r;
    logic [DT_W-1:0] dt_r;
    logic [2:0]      state_r     [CH];
    logic [DT_W-1:0] cnt_r       [CH];
    logic [2:0]      state_nxt_s [CH];
    logic [DT_W-1:0] cnt_nxt_s   [CH];
    logic [CH-1:0]   hi_nxt_s;
    logic [CH-1:0]   lo_nxt_s;
    logic [CH-1:0]   hi_r;
    logic [CH-1:0]   lo_r;
    logic [CH-1:0]   pol_hi_s;
    logic [CH-1:0]   pol_lo_s;
    logic            wr_s;
    logic            active_s;
    logic            unused_s;

    assign wr_s     = cs & write;
    assign active_s = en_r & ~fault_r;
    assign unused_s = read ^ (^wr_data);
    assign pwm_hi   = hi_r;
    assign pwm_lo   = lo_r;

    // Control, dead-time and fault latch registers; a fault set beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_r    <= 1'b0;
            dt_r    <= DT_RST;
            fault_r <= 1'b0;
        end else begin
            if (wr_s && reg_addr == 5'h00) begin
                en_r <= wr_data[0];
            end
            if (wr_s && reg_addr == 5'h01) begin
                dt_r <= wr_data[DT_W-1:0];
            end
            if (fault_in) begin
                fault_r <= 1'b1;
            end else if (wr_s && reg_addr == 5'h00 && wr_data[1]) begin
                fault_r <= 1'b0;
            end
        end
    end

`ifdef PWM_DT_POL_EN
    logic [CH-1:0] pol_hi_r;
    logic [CH-1:0] pol_lo_r;

    // Output polarity register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pol_hi_r <= {CH{1'b0}};
            pol_lo_r <= {CH{1'b0}};
        end else if (wr_s && reg_addr == 5'h03) begin
            pol_hi_r <= wr_data[CH-1:0];
            pol_lo_r <= wr_data[CH+15:16];
        end
    end

    assign pol_hi_s = pol_hi_r;
    assign pol_lo_s = pol_lo_r;
`else
    assign pol_hi_s = {CH{1'b0}};
    assign pol_lo_s = {CH{1'b0}};
`endif

    // Per-channel next-state and dead-time counter; loss of active forces OFF ahead of all else.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_nxt_s[i] = state_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            if (!active_s) begin
                state_nxt_s[i] = ST_OFF;
                cnt_nxt_s[i]   = {DT_W{1'b0}};
            end else begin
                case (state_r[i])
                    ST_OFF: begin
                        if (pwm_in[i]) begin
                            state_nxt_s[i] = ST_DT_H;
                            cnt_nxt_s[i]   = dt_r;
                        end else begin
                            state_nxt_s[i] = ST_LO_ON;
                        end
                    end
                    ST_LO_ON: begin
                        if (pwm_in[i]) begin
                            state_nxt_s[i] = ST_DT_H;
                            cnt_nxt_s[i]   = dt_r;
                        end else begin
                            state_nxt_s[i] = ST_LO_ON;
                        end
                    end
                    ST_DT_H: begin
                        if (!pwm_in[i]) begin
                            state_nxt_s[i] = ST_LO_ON;
                        end else if (cnt_r[i] == {DT_W{1'b0}}) begin
                            state_nxt_s[i] = ST_HI_ON;
                        end else begin
                            cnt_nxt_s[i] = cnt_r[i] - {{(DT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_HI_ON: begin
                        if (!pwm_in[i]) begin
                            state_nxt_s[i] = ST_DT_L;
                            cnt_nxt_s[i]   = dt_r;
                        end else begin
                            state_nxt_s[i] = ST_HI_ON;
                        end
                    end
                    ST_DT_L: begin
                        if (pwm_in[i]) begin
                            state_nxt_s[i] = ST_HI_ON;
                        end else if (cnt_r[i] == {DT_W{1'b0}}) begin
                            state_nxt_s[i] = ST_LO_ON;
                        end else begin
                            cnt_nxt_s[i] = cnt_r[i] - {{(DT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state_nxt_s[i] = ST_OFF;
                        cnt_nxt_s[i]   = {DT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Output decode of the next state so gates switch on the same edge as the FSM.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            hi_nxt_s[i] = (state_nxt_s[i] == ST_HI_ON) ^ pol_hi_s[i];
            lo_nxt_s[i] = (state_nxt_s[i] == ST_LO_ON) ^ pol_lo_s[i];
        end
    end

    // FSM state, counters and gate output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                state_r[i] <= ST_OFF;
                cnt_r[i]   <= {DT_W{1'b0}};
            end
            hi_r <= {CH{1'b0}};
            lo_r <= {CH{1'b0}};
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_r[i] <= state_nxt_s[i];
                cnt_r[i]   <= cnt_nxt_s[i];
            end
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
        end
    end

    // Register read mux, decoded from the address alone.
    always_comb begin
        rd_data = 32'd0;
        case (reg_addr)
            5'h00: rd_data[0] = en_r;
            5'h01: rd_data[DT_W-1:0] = dt_r;
            5'h02: begin
                rd_data[0]      = fault_r;
                rd_data[CH+7:8] = pwm_in;
            end
`ifdef PWM_DT_POL_EN
            5'h03: begin
                rd_data[CH-1:0]   = pol_hi_s;
                rd_data[CH+15:16] = pol_lo_s;
            end
`endif
            default: rd_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_pwm_deadtime_core.sv
// Scoreboard bench for pwm_deadtime_core: expected gate vectors are queued as stimulus is driven
// and compared one edge later; the non-overlap invariant is checked on every cycle.
module tb_pwm_deadtime_core;

    localparam int CH = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs;
    logic          read;
    logic          write;
    logic [4:0]    reg_addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic [CH-1:0] pwm_in;
    logic          fault_in;
    logic [CH-1:0] pwm_hi;
    logic [CH-1:0] pwm_lo;

    typedef struct packed {
        logic [CH-1:0] hi;
        logic [CH-1:0] lo;
    } exp_t;

    exp_t          sb_q[$];
    string         tag_q[$];
    int            total = 0;
    int            bad = 0;
    logic [CH-1:0] pol_h = {CH{1'b0}};
    logic [CH-1:0] pol_l = {CH{1'b0}};

    pwm_deadtime_core #(.CH(CH), .DT_W(16), .DT_RST(16'd10)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data),
        .pwm_in(pwm_in), .fault_in(fault_in), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: invariant every cycle, scoreboard entry when one is pending.
    always @(posedge clk) begin
        exp_t  e;
        string t;
        #1;
        chk("novl", 32'((pwm_hi ^ pol_h) & (pwm_lo ^ pol_l)), 32'd0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            chk({t, "_hi"}, 32'(pwm_hi), 32'(e.hi));
            chk({t, "_lo"}, 32'(pwm_lo), 32'(e.lo));
        end
    end

    // One clock of stimulus; raw (active-level) expectations for channel 0 and the other channels' lo.
    task automatic tick(input string tag, input logic p0, input logic f,
                        input logic h0, input logic l0, input logic oth);
        exp_t e;
        e.hi = {{(CH-1){1'b0}}, h0} ^ pol_h;
        e.lo = {{(CH-1){oth}}, l0} ^ pol_l;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        pwm_in[0] = p0;
        fault_in  = f;
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_addr = a;
        wr_data  = d;
        cs       = 1'b1;
        write    = 1'b1;
        @(posedge clk);
        #2;
        cs       = 1'b0;
        write    = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        reg_addr = a;
        cs       = 1'b1;
        read     = 1'b1;
        #1;
        chk(tag, rd_data, exp);
        cs       = 1'b0;
        read     = 1'b0;
    endtask

    initial begin
        cs = 1'b0; read = 1'b0; write = 1'b0; reg_addr = 5'd0; wr_data = 32'd0;
        pwm_in = {CH{1'b0}}; fault_in = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("rst_hi", 32'(pwm_hi), 32'd0);
        chk("rst_lo", 32'(pwm_lo), 32'd0);
        rd(5'h00, 32'd0, "rst_ctrl");
        rd(5'h01, 32'd10, "rst_dt");
        rd(5'h02, 32'd0, "rst_stat");
        rd(5'h03, 32'd0, "rst_pol");

        // Enable: lo asserts one edge after EN latches.
        wr(5'h01, 32'd10);
        wr(5'h00, 32'd1);
        chk("en_edge_lo", 32'(pwm_lo), 32'd0);
        rd(5'h01, 32'd10, "dt_rd");
        tick("lo_on", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("lo_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Rising edge at k, hi at k+11; then the mirrored falling edge.
        tick("rise_k", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) tick($sformatf("dth%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("hi_k11", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick("hi_hold", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick("fall_k", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) tick($sformatf("dtl%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("lo_k11", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Short pulse inside a 20-cycle dead time never reaches hi.
        wr(5'h01, 32'd20);
        tick("ab_rise", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) tick($sformatf("ab_dt%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("ab_fall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) tick($sformatf("ab_lo%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // DT=0, period-8 square wave: 1 dead, 3 hi, 1 dead, 3 lo.
        wr(5'h01, 32'd0);
        for (int p = 0; p < 3; p++) begin
            tick($sformatf("z%0d_dh", p), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) tick($sformatf("z%0d_hi%0d", p, i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            tick($sformatf("z%0d_dl", p), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) tick($sformatf("z%0d_lo%0d", p, i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end

        // Fault pulse during HI_ON, blocked clear, real clear, restart via OFF->DT_H.
        wr(5'h01, 32'd2);
        tick("f_rise", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("f_dt1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("f_dt2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("f_hi", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick("f_pulse", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick("f_off", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("f_off2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rd(5'h02, 32'h0000_0101, "stat_fault");
        fault_in = 1'b1;
        wr(5'h00, 32'd3);
        fault_in = 1'b0;
        rd(5'h02, 32'h0000_0101, "clr_blocked");
        tick("f_still", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wr(5'h00, 32'd3);
        rd(5'h02, 32'h0000_0100, "clr_ok");
        rd(5'h00, 32'd1, "ctrl_en");
        tick("r_dth", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("r_dt1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("r_dt2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("r_hi", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // EN=0 forces everything off on the next edge.
        wr(5'h00, 32'd0);
        tick("en_off", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a dead time.
        wr(5'h00, 32'd1);
        tick("m_dth", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("m_dt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        chk("rst2_hi", 32'(pwm_hi), 32'd0);
        chk("rst2_lo", 32'(pwm_lo), 32'd0);
        rd(5'h00, 32'd0, "rst2_ctrl");
        rd(5'h01, 32'd10, "rst2_dt");

        wr(5'h04, 32'hFFFF_FFFF);
        rd(5'h04, 32'd0, "unmap4");
        pwm_in = {CH{1'b0}};
`ifdef PWM_DT_POL_EN
        wr(5'h03, 32'h0001_0001);
        pol_h = {{(CH-1){1'b0}}, 1'b1};
        pol_l = {{(CH-1){1'b0}}, 1'b1};
        rd(5'h03, 32'h0001_0001, "pol_rd");
        wr(5'h00, 32'd1);
        tick("pol_lo", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("pol_rise", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        wr(5'h03, 32'hFFFF_FFFF);
        rd(5'h03, 32'd0, "pol_unmap");
        wr(5'h00, 32'd1);
        tick("np_lo", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("np_rise", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        #2;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
